// File: rtl/uart_matmul_ctrl.sv
// Frame controller: gathers A5-headed A/B operand frames from the UART, starts the multiplier,
// then streams each result word back out MSB byte first. Single clock, synchronous active-high reset.
module uart_matmul_ctrl #(
  parameter int          N       = 2,
  parameter int          ADDR_W  = 2,
  parameter int          RES_W   = 16,
  parameter logic [7:0]  HEADER  = 8'hA5,
  parameter int          TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              a_we,
  output logic              b_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              mm_start,
  input  logic              mm_done,
  output logic [ADDR_W-1:0] res_addr,
  input  logic [RES_W-1:0]  res_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(N*N - 1);
  localparam logic [TW-1:0]     TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD_A, LOAD_B, START, WAIT_MM, RD, RD_WAIT,
    SEND_HI, GUARD_HI, WAIT_HI, SEND_LO, GUARD_LO, WAIT_LO
  } state_t;

  state_t            state, next;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] ridx;
  logic [TW-1:0]     tcnt;
  logic [RES_W-1:0]  word;
  logic [15:0]       word16;

  assign word16 = 16'(word);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:     if (rx_valid && rx_data == HEADER) next = LOAD_A;
      LOAD_A: begin
        if (rx_valid) begin
          if (cnt == LAST) next = LOAD_B;
        end else if (tcnt == TLAST) begin
          next = IDLE;
        end
      end
      LOAD_B: begin
        if (rx_valid) begin
          if (cnt == LAST) next = START;
        end else if (tcnt == TLAST) begin
          next = IDLE;
        end
      end
      START:    next = WAIT_MM;
      WAIT_MM:  if (mm_done) next = RD;
      RD:       next = RD_WAIT;
      RD_WAIT:  next = SEND_HI;
      SEND_HI:  if (!tx_busy) next = GUARD_HI;
      GUARD_HI: next = WAIT_HI;
      WAIT_HI:  if (!tx_busy) next = SEND_LO;
      SEND_LO:  if (!tx_busy) next = GUARD_LO;
      GUARD_LO: next = WAIT_LO;
      WAIT_LO:  if (!tx_busy) next = (ridx == LAST) ? IDLE : RD;
      default:  next = IDLE;
    endcase
  end

  always_comb begin
    mm_start = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    busy     = (state != IDLE);
    res_addr = ridx;
    case (state)
      START:   mm_start = 1'b1;
      SEND_HI: begin
        tx_data  = word16[15:8];
        tx_start = !tx_busy;
      end
      SEND_LO: begin
        tx_data  = word16[7:0];
        tx_start = !tx_busy;
      end
      default: ;
    endcase
  end

  // Operand write strobes are registered so they land one cycle after the accepted byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_we    <= 1'b0;
      b_we    <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      cnt     <= '0;
      tcnt    <= '0;
      ridx    <= '0;
      word    <= '0;
      err     <= 1'b0;
    end else begin
      a_we <= 1'b0;
      b_we <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid && rx_data == HEADER) begin
            cnt  <= '0;
            tcnt <= '0;
            err  <= 1'b0;
          end
        end
        LOAD_A, LOAD_B: begin
          if (rx_valid) begin
            a_we    <= (state == LOAD_A);
            b_we    <= (state == LOAD_B);
            wr_addr <= cnt;
            wr_data <= rx_data;
            cnt     <= (cnt == LAST) ? '0 : cnt + ADDR_W'(1);
            tcnt    <= '0;
          end else if (tcnt == TLAST) begin
            tcnt <= '0;
            cnt  <= '0;
            err  <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        WAIT_MM: if (mm_done) ridx <= '0;
        RD_WAIT: word <= res_data;
        WAIT_LO: if (!tx_busy && ridx != LAST) ridx <= ridx + ADDR_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_matmul_ctrl.sv
// Self-checking bench for uart_matmul_ctrl with multiplier, result RAM and UART transmitter models.
module tb_uart_matmul_ctrl;
  localparam int N  = 2;
  localparam int AW = 2;
  localparam int RW = 16;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          a_we, b_we, mm_start, mm_done, tx_start, tx_busy, busy, err;
  logic [AW-1:0] wr_addr, res_addr;
  logic [7:0]    wr_data, tx_data;
  logic [RW-1:0] res_data = '0;

  uart_matmul_ctrl #(.N(N), .ADDR_W(AW), .RES_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .a_we(a_we), .b_we(b_we), .wr_addr(wr_addr), .wr_data(wr_data),
    .mm_start(mm_start), .mm_done(mm_done), .res_addr(res_addr), .res_data(res_data),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [10:0]   wlog[$];
  logic [7:0]    txq[$];
  int            mm_starts = 0;
  logic [7:0]    amem[N*N];
  logic [7:0]    bmem[N*N];
  logic [RW-1:0] rmem[N*N];
  int            mm_delay = -1;
  logic          mm_done_m = 1'b0;
  logic          mm_done_i = 1'b0;
  logic          start_ph = 1'b0;
  int            txc = 0;
  logic          tx_hold = 1'b0;

  assign mm_done = mm_done_m | mm_done_i;
  assign tx_busy = (txc > 0) || tx_hold;

  // Observe DUT outputs mid-cycle; model operand RAMs and the multiplier.
  always @(negedge clk) begin
    start_ph = tx_start;
    if (tx_start) txq.push_back(tx_data);
    if (a_we) begin wlog.push_back({1'b0, wr_addr, wr_data}); amem[wr_addr] = wr_data; end
    if (b_we) begin wlog.push_back({1'b1, wr_addr, wr_data}); bmem[wr_addr] = wr_data; end
    mm_done_m = 1'b0;
    if (mm_start) begin
      mm_starts++;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          int s;
          s = 0;
          for (int k = 0; k < N; k++) s += int'(amem[i*N+k]) * int'(bmem[k*N+j]);
          rmem[i*N+j] = RW'(s);
        end
      mm_delay = 10;
    end else if (mm_delay > 0) begin
      mm_delay--;
      if (mm_delay == 0) begin mm_done_m = 1'b1; mm_delay = -1; end
    end
    if (rst) mm_delay = -1;
  end

  always @(posedge clk) res_data <= rmem[res_addr];

  // Transmitter raises busy just after the edge that accepts tx_start.
  always @(posedge clk) begin
    #1;
    if (rst)           txc = 0;
    else if (start_ph) txc = 3;
    else if (txc > 0)  txc--;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick(gap);
  endtask

  task automatic clear_logs();
    wlog.delete();
    txq.delete();
    mm_starts = 0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b after %0d cycles, expected 0", nm, busy, n);
    end
  endtask

  task automatic check_frame(input string nm, input logic [7:0] a[N*N], input logic [7:0] b[N*N]);
    logic [10:0] ew[$];
    logic [7:0]  et[$];
    for (int i = 0; i < N*N; i++) ew.push_back({1'b0, AW'(i), a[i]});
    for (int i = 0; i < N*N; i++) ew.push_back({1'b1, AW'(i), b[i]});
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int c;
        c = 0;
        for (int k = 0; k < N; k++) c += int'(a[i*N+k]) * int'(b[k*N+j]);
        et.push_back(c[15:8]);
        et.push_back(c[7:0]);
      end
    checks++;
    if (wlog.size() != ew.size()) begin
      errors++;
      $display("FAIL %s_nwrites: got %0d expected %0d", nm, wlog.size(), ew.size());
    end
    for (int i = 0; i < ew.size(); i++) begin
      checks++;
      if (i >= wlog.size() || wlog[i] !== ew[i]) begin
        errors++;
        $display("FAIL %s_write%0d: got %h expected %h", nm, i, (i < wlog.size()) ? wlog[i] : 11'h7ff, ew[i]);
      end
    end
    checks++;
    if (txq.size() != et.size()) begin
      errors++;
      $display("FAIL %s_ntx: got %0d expected %0d", nm, txq.size(), et.size());
    end
    for (int i = 0; i < et.size(); i++) begin
      checks++;
      if (i >= txq.size() || txq[i] !== et[i]) begin
        errors++;
        $display("FAIL %s_tx%0d: got %h expected %h", nm, i, (i < txq.size()) ? txq[i] : 8'hxx, et[i]);
      end
    end
    checks++;
    if (mm_starts != 1) begin
      errors++;
      $display("FAIL %s_mm_start: got %0d pulses expected 1", nm, mm_starts);
    end
  endtask

  task automatic frame_body(input string nm, input logic [7:0] a[N*N], input logic [7:0] b[N*N], input int maxgap);
    for (int i = 0; i < N*N; i++) send(a[i], $urandom_range(0, maxgap));
    for (int i = 0; i < N*N; i++) send(b[i], $urandom_range(0, maxgap));
    wait_idle(nm);
    check_frame(nm, a, b);
  endtask

  task automatic run_frame(input string nm, input logic [7:0] a[N*N], input logic [7:0] b[N*N], input int maxgap);
    clear_logs();
    send(8'hA5, 0);
    frame_body(nm, a, b, maxgap);
  endtask

  task automatic rand_ops(output logic [7:0] a[N*N], output logic [7:0] b[N*N]);
    for (int i = 0; i < N*N; i++) begin
      a[i] = 8'($urandom);
      b[i] = 8'($urandom);
    end
  endtask

  task automatic check_outputs_zero(input string nm);
    logic [31:0] got;
    got = {a_we, b_we, wr_addr, wr_data, mm_start, res_addr, tx_data, tx_start, busy, err};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL %s: outputs=%h expected 0", nm, got);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    check_outputs_zero("reset_outputs");
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_full_frame();
    logic [7:0] a[N*N];
    logic [7:0] b[N*N];
    a = '{8'd1, 8'd2, 8'd3, 8'd4};
    b = '{8'd5, 8'd6, 8'd7, 8'd8};
    run_frame("full", a, b, 0);
  endtask

  task automatic test_header_filter();
    logic [7:0] a[N*N];
    logic [7:0] b[N*N];
    clear_logs();
    send(8'h00, 0);
    send(8'h5A, 0);
    send(8'hFF, 1);
    checks++;
    if (busy !== 1'b0 || wlog.size() != 0) begin
      errors++;
      $display("FAIL hdr_filter: busy=%b writes=%0d expected busy 0 writes 0", busy, wlog.size());
    end
    send(8'hA5, 0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL hdr_accept: busy=%b expected 1", busy);
    end
    rand_ops(a, b);
    a[1] = 8'hA5;
    b[0] = 8'hA5;
    frame_body("hdr_frame", a, b, 2);
  endtask

  task automatic test_timeout();
    logic [7:0] a[N*N];
    logic [7:0] b[N*N];
    clear_logs();
    send(8'hA5, 0);
    send(8'h01, 0);
    send(8'h02, 0);
    send(8'h03, 0);
    tick(TO - 2);
    checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: busy=%b err=%b expected busy 1 err 0", busy, err);
    end
    tick(3);
    checks++;
    if (busy !== 1'b0 || err !== 1'b1 || mm_starts != 0) begin
      errors++;
      $display("FAIL timeout_fire: busy=%b err=%b mm_start=%0d expected 0 1 0", busy, err, mm_starts);
    end
    send(8'h00, 0);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: err=%b expected 1", err);
    end
    clear_logs();
    send(8'hA5, 0);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_clear: err=%b busy=%b expected 0 1", err, busy);
    end
    rand_ops(a, b);
    frame_body("timeout_frame", a, b, 3);
  endtask

  task automatic test_ignored();
    logic [7:0] a[N*N];
    logic [7:0] b[N*N];
    rand_ops(a, b);
    clear_logs();
    send(8'hA5, 0);
    for (int i = 0; i < N*N; i++) send(a[i], 0);
    send(b[0], 0);
    send(b[1], 0);
    mm_done_i = 1'b1;
    tick(1);
    mm_done_i = 1'b0;
    send(b[2], 0);
    send(b[3], 2);
    send(8'hA5, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ignored_busy: busy=%b expected 1", busy);
    end
    wait_idle("ignored");
    check_frame("ignored", a, b);
  endtask

  task automatic test_backpressure();
    logic [7:0] a[N*N];
    logic [7:0] b[N*N];
    int n;
    rand_ops(a, b);
    clear_logs();
    tx_hold = 1'b1;
    send(8'hA5, 0);
    for (int i = 0; i < N*N; i++) send(a[i], 0);
    for (int i = 0; i < N*N; i++) send(b[i], 0);
    n = 0;
    while (mm_done !== 1'b1 && n < 200) begin @(negedge clk); #1; n++; end
    checks++;
    if (mm_done !== 1'b1) begin
      errors++;
      $display("FAIL bp_mm_done: mm_done never seen after %0d cycles", n);
    end
    tick(50);
    checks++;
    if (txq.size() != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: tx_starts=%0d busy=%b expected 0 1", txq.size(), busy);
    end
    tx_hold = 1'b0;
    wait_idle("bp");
    check_frame("bp", a, b);
  endtask

  task automatic test_reset_mid();
    logic [7:0] a[N*N];
    logic [7:0] b[N*N];
    clear_logs();
    send(8'hA5, 0);
    for (int i = 0; i < N*N; i++) send(8'($urandom), 0);
    send(8'h33, 0);
    send(8'h44, 0);
    rst = 1'b1;
    tick(1);
    check_outputs_zero("reset_mid_outputs");
    rst = 1'b0;
    tick(2);
    checks++;
    if (mm_starts != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_quiet: mm_start=%0d busy=%b expected 0 0", mm_starts, busy);
    end
    rand_ops(a, b);
    run_frame("after_reset", a, b, 1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] a[N*N];
    logic [7:0] b[N*N];
    for (int r = 0; r < 4; r++) begin
      rand_ops(a, b);
      run_frame($sformatf("b2b%0d", r), a, b, (r == 0) ? 0 : 4);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_header_filter();
    test_timeout();
    test_ignored();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
